// File: rtl/multi_chan_data_cnt_pkg.sv
// multi_chan_data_cnt_pkg: shared state encoding and length-field helper
package multi_chan_data_cnt_pkg;
  localparam int ST_W = 2;
  localparam int MAX_VEC = 256;
  localparam int MAX_LEN_W = 16;
  typedef enum logic [ST_W-1:0] {IDLE, ARM, RUN, DONE} state_e;
  function automatic logic [MAX_LEN_W-1:0] len_slice(input logic [MAX_VEC-1:0] v, input int c, input int w);
    return MAX_LEN_W'(v >> (c * w));
  endfunction
endpackage

// File: rtl/next_chan_sel.sv
// next_chan_sel: lowest active channel at or above a start index
module next_chan_sel #(
  parameter int NUM_CHAN = 4,
  parameter int CH_W = 2
) (
  input  logic [NUM_CHAN-1:0] mask_i,
  input  logic [CH_W-1:0]     start_i,
  input  logic                incl_i,
  output logic [CH_W-1:0]     nxt_idx_o,
  output logic                nxt_vld_o
);
  // descending scan so the lowest qualifying index is the one left standing
  always_comb begin
    nxt_idx_o = '0;
    nxt_vld_o = 1'b0;
    for (int i = NUM_CHAN - 1; i >= 0; i--)
      if (mask_i[i] && (CH_W'(i) > start_i || (incl_i && CH_W'(i) == start_i))) begin
        nxt_idx_o = CH_W'(i);
        nxt_vld_o = 1'b1;
      end
  end
endmodule

// File: rtl/multi_chan_data_cnt.sv
// multi_chan_data_cnt: frame-synchronous per-channel word counter
module multi_chan_data_cnt
  import multi_chan_data_cnt_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int NUM_CHAN = 4,
  parameter int CH_W = 2
) (
  input  logic                      clk20,
  input  logic                      res_n,
  input  logic                      sync_n,
  input  logic [NUM_CHAN*CNT_W-1:0] words_num,
  input  logic [NUM_CHAN-1:0]       chan_en,
  input  logic                      word_stb,
  output logic [CNT_W-1:0]          data_count,
  output logic [CH_W-1:0]           chan_idx,
  output logic                      data_valid,
  output logic                      chan_cmpl,
  output logic [CH_W-1:0]           cmpl_idx,
  output logic                      frame_cmpl,
  output logic                      sync_err
);
  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d, cur_len;
  logic [CH_W-1:0]           idx_q, idx_d, cmpl_idx_q, cmpl_idx_d, sel_start, nxt_idx;
  logic                      cmpl_q, cmpl_d, err_q, err_d, nxt_vld, last, sel_incl;
  logic [NUM_CHAN*CNT_W-1:0] words_q, words_d;
  logic [NUM_CHAN-1:0]       en_q, en_d, act_in, act_lat, sel_mask;

  function automatic logic [CNT_W-1:0] len_of(input logic [NUM_CHAN*CNT_W-1:0] v, input int c);
    return CNT_W'(len_slice(MAX_VEC'(v), c, CNT_W));
  endfunction

  // active = enabled and non-zero length; live inputs for ARM exit, latched copy during RUN
  always_comb begin
    act_in = '0;
    act_lat = '0;
    for (int c = 0; c < NUM_CHAN; c++) begin
      act_in[c] = chan_en[c] && (len_of(words_num, c) != '0);
      act_lat[c] = en_q[c] && (len_of(words_q, c) != '0);
    end
  end

  assign cur_len = len_of(words_q, int'(idx_q));
  assign last = cnt_q == cur_len - CNT_W'(1);
  assign sel_mask = state_q == ARM ? act_in : act_lat;
  assign sel_start = state_q == ARM ? '0 : idx_q;
  assign sel_incl = state_q == ARM;

  next_chan_sel #(.NUM_CHAN(NUM_CHAN), .CH_W(CH_W)) u_sel (
    .mask_i(sel_mask), .start_i(sel_start), .incl_i(sel_incl),
    .nxt_idx_o(nxt_idx), .nxt_vld_o(nxt_vld)
  );

  // sync overrides everything; ARM exit latches the frame setup; RUN counts and advances
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    words_d = words_q;
    en_d = en_q;
    cmpl_d = 1'b0;
    cmpl_idx_d = cmpl_idx_q;
    err_d = 1'b0;
    if (!sync_n) begin
      state_d = ARM;
      cnt_d = '0;
      idx_d = '0;
      err_d = state_q == RUN;
    end else if (state_q == ARM) begin
      words_d = words_num;
      en_d = chan_en;
      idx_d = nxt_vld ? nxt_idx : '0;
      state_d = nxt_vld ? RUN : DONE;
    end else if (state_q == RUN && word_stb) begin
      cnt_d = last ? '0 : cnt_q + CNT_W'(1);
      cmpl_d = last;
      cmpl_idx_d = last ? idx_q : cmpl_idx_q;
      idx_d = last && nxt_vld ? nxt_idx : idx_q;
      state_d = last && !nxt_vld ? DONE : RUN;
    end
  end

  // state and pulse registers with synchronous active-low reset
  always_ff @(posedge clk20) begin
    if (!res_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      words_q <= '0;
      en_q <= '0;
      cmpl_q <= 1'b0;
      cmpl_idx_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      words_q <= words_d;
      en_q <= en_d;
      cmpl_q <= cmpl_d;
      cmpl_idx_q <= cmpl_idx_d;
      err_q <= err_d;
    end
  end

  assign data_count = cnt_q;
  assign chan_idx = idx_q;
  assign chan_cmpl = cmpl_q;
  assign cmpl_idx = cmpl_idx_q;
  assign sync_err = err_q;
  assign data_valid = state_q == RUN && word_stb;
  assign frame_cmpl = (state_q == IDLE || state_q == DONE) && sync_n;
endmodule
